// File: rtl/wisc_shift_pkg.sv
// Shared definitions for the WiscSP-13 shift/rotate units: op encodings,
// sequencer states and default geometry.
package wisc_shift_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a stage index; never zero so a one-stage build still has a port.
    function automatic int idx_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional shift/rotate by 2^stage. Shared by every iteration of the
// sequencer, so the stage index selects the distance at run time.
module shift_stage
    import wisc_shift_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int SW     = idx_width(STAGES)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic [SW-1:0]    stage,
    input  logic             en,
    output logic [WIDTH-1:0] shifted
);

    localparam int AW = $clog2(WIDTH) + 1;

    logic [AW-1:0]        amt;
    logic [2*WIDTH-1:0]   dbl;
    logic [2*WIDTH-1:0]   rol_full;
    logic [2*WIDTH-1:0]   ror_full;
    logic [WIDTH-1:0]     result;

    assign amt = AW'(1) << stage;
    assign dbl = {data, data};
    // Rotations shift a doubled copy so the wrapped bits come along for free.
    assign rol_full = dbl << amt;
    assign ror_full = dbl >> amt;

    always_comb begin
        result = data;
        case (op)
            OP_ROL:  result = rol_full[2*WIDTH-1:WIDTH];
            OP_SLL:  result = data << amt;
            OP_ROR:  result = ror_full[WIDTH-1:0];
            OP_SRA:  result = $signed(data) >>> amt;
            default: result = data;
        endcase
    end

    assign shifted = en ? result : data;

endmodule

// File: rtl/iter_lrotator.sv
// Iterative shift/rotate unit: one count bit per cycle behind a start/busy/done
// handshake. Define ITER_LROTATOR_EARLY_DONE_EN to finish once no count bits remain.
module iter_lrotator
    import wisc_shift_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  In,
    input  logic [STAGES-1:0] Cnt,
    input  logic [1:0]        Op,
    output logic [WIDTH-1:0]  Out,
    output logic              busy,
    output logic              done
);

    localparam int SW = idx_width(STAGES);

    state_t            state;
    logic [WIDTH-1:0]  data;
    logic [STAGES-1:0] cnt;
    logic [1:0]        op;
    logic [SW-1:0]     stage;
    logic [WIDTH-1:0]  shifted;
    logic              finish;

    shift_stage #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .SW     (SW)
    ) u_stage (
        .data    (data),
        .op      (op),
        .stage   (stage),
        .en      (cnt[stage]),
        .shifted (shifted)
    );

`ifdef ITER_LROTATOR_EARLY_DONE_EN
    // Stop as soon as every count bit above the current stage is clear.
    assign finish = (stage == SW'(STAGES - 1)) || (((cnt >> stage) >> 1) == '0);
`else
    assign finish = (stage == SW'(STAGES - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            op    <= '0;
            stage <= '0;
            Out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        data  <= In;
                        cnt   <= Cnt;
                        op    <= Op;
                        stage <= '0;
`ifdef ITER_LROTATOR_EARLY_DONE_EN
                        if (Cnt == '0) begin
                            Out   <= In;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
`else
                        busy  <= 1'b1;
                        state <= SHIFT;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    data  <= shifted;
                    stage <= stage + 1'b1;
                    if (finish) begin
                        Out   <= shifted;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_lrotator.sv
// Scoreboard bench for iter_lrotator: directed cases from the shifter's
// corner list, mid-shift reset, then randomized traffic with ignored starts.
module tb_iter_lrotator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    iter_lrotator #(.WIDTH(16), .STAGES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [15:0] out;
        int          due;
        int          id;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          txn    = 0;
    logic [15:0] exp_hold;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: rotations/shifts as multiply/divide by powers of two, SRA as floor division.
    function automatic logic [15:0] model(input logic [15:0] x, input int c, input logic [1:0] o);
        int ux, p, sx, q, r;
        ux = int'(x);
        p  = 1 << c;
        r  = 0;
        case (o)
            2'b00: r = ((ux * p) % 65536) + (ux / (65536 / p));
            2'b01: r = (ux * p) % 65536;
            2'b10: r = (ux / p) + (ux % p) * (65536 / p);
            default: begin
                sx = (ux >= 32768) ? ux - 65536 : ux;
                q  = sx / p;
                if ((sx % p) != 0 && sx < 0) q = q - 1;
                r  = q;
            end
        endcase
        return r[15:0];
    endfunction

    // Edges from the accepting edge to the edge that raises done.
    function automatic int lat(input int c);
`ifdef ITER_LROTATOR_EARLY_DONE_EN
        if (c == 0) return 0;
        for (int k = 3; k >= 0; k--)
            if (((c >> k) & 1) == 1) return k + 1;
        return 0;
`else
        return 4;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", 32'(Out), 32'(e.out));
                check("latency", 32'(cyc), 32'(e.due));
                $display("txn %0d: Out=%04h (exp %04h) done at cycle %0d (exp %0d)",
                         e.id, Out, e.out, cyc, e.due);
            end
        end
    end

    // Entered just after a negedge; returns at the negedge of the DONE cycle.
    task automatic run_op(input logic [15:0] x, input int c, input logic [1:0] o, input bit noise);
        exp_t e;
        int   l;
        l     = lat(c);
        e.out = model(x, c, o);
        e.due = cyc + 1 + l;
        e.id  = txn++;
        start = 1'b1;
        In    = x;
        Cnt   = c[3:0];
        Op    = o;
        sbq.push_back(e);
        @(posedge clk);
        for (int j = 1; j <= l; j++) begin
            @(negedge clk);
            check("busy_in_shift", 32'(busy), 32'(1));
            check("out_hold", 32'(Out), 32'(exp_hold));
            start = noise ? 1'($urandom) : 1'b0;
            In    = 16'($urandom);
            Cnt   = 4'($urandom);
            Op    = 2'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_at_done", 32'(busy), 32'(0));
        exp_hold = e.out;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        In       = '0;
        Cnt      = '0;
        Op       = '0;
        exp_hold = '0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(Out), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(16'h8001, 1, 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        run_op(16'h00FF, 12, 2'b01, 1'b0);
        run_op(16'h0001, 15, 2'b10, 1'b0);
        repeat (1) @(negedge clk);
        run_op(16'h8000, 15, 2'b11, 1'b1);
        run_op(16'h4000, 14, 2'b11, 1'b1);
        run_op(16'h1234, 0, 2'b00, 1'b0);
        run_op(16'hA5A5, 3, 2'b10, 1'b1);
        run_op(16'h0F0F, 8, 2'b11, 1'b0);
        repeat (2) @(negedge clk);

        // Abort mid-shift: two stage edges in, then reset asynchronously.
        start = 1'b1;
        In    = 16'h00F0;
        Cnt   = 4'd15;
        Op    = 2'b00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out", 32'(Out), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        sbq.delete();
        exp_hold = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'(0));

        for (int i = 0; i < 200; i++) begin
            run_op(16'($urandom), int'($urandom_range(0, 15)), 2'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("drain", 32'(sbq.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
